// File: rtl/tc_to_signmag_norm.sv
// Two's-complement to sign/magnitude converter with iterative left normalization.
// One word in flight; the shift count feeds exponent adjustment downstream.
module tc_to_signmag_norm #(
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [DATA_WIDTH-1:0] out_mag,
  output logic [SHIFT_W-1:0]    out_shift,
  output logic                  out_zero
);

  typedef enum logic [1:0] {IDLE, CONV, NORM, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_mag;
  logic                  r_sign;
  logic [SHIFT_W-1:0]    r_cnt;
  logic                  r_out_sign;
  logic [DATA_WIDTH-1:0] r_out_mag;
  logic [SHIFT_W-1:0]    r_out_shift;
  logic                  r_out_zero;
  logic [DATA_WIDTH-1:0] w_abs;
  logic                  w_mag_zero;
  logic                  w_mag_top;

  // Most-negative input negates to itself, which is exactly 2^(N-1) unsigned.
  assign w_abs      = r_word[DATA_WIDTH-1] ? (~r_word + DATA_WIDTH'(1)) : r_word;
  assign w_mag_zero = (r_mag == '0);
  assign w_mag_top  = r_mag[DATA_WIDTH-1];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sign  = r_out_sign;
  assign out_mag   = r_out_mag;
  assign out_shift = r_out_shift;
  assign out_zero  = r_out_zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CONV;
      CONV:    w_next = NORM;
      NORM:    if (w_mag_zero || w_mag_top) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_mag       <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_out_sign  <= 1'b0;
      r_out_mag   <= '0;
      r_out_shift <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) r_word <= in_data;
        CONV: begin
          r_sign <= r_word[DATA_WIDTH-1];
          r_mag  <= w_abs;
          r_cnt  <= '0;
        end
        NORM: begin
          // Output registers load only on completion so they hold between results.
          if (w_mag_zero) begin
            r_out_sign  <= r_sign;
            r_out_mag   <= '0;
            r_out_shift <= '0;
            r_out_zero  <= 1'b1;
          end else if (w_mag_top) begin
            r_out_sign  <= r_sign;
            r_out_mag   <= r_mag;
            r_out_shift <= r_cnt;
            r_out_zero  <= 1'b0;
          end else begin
            r_mag <= {r_mag[DATA_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + SHIFT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_to_signmag_norm.sv
// Scoreboard bench for tc_to_signmag_norm: driver pushes model results, monitor pops on handshake.
module tb_tc_to_signmag_norm;
  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [DW-1:0] out_mag;
  logic [SW-1:0] out_shift;
  logic          out_zero;

  tc_to_signmag_norm #(.DATA_WIDTH(DW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_mag(out_mag),
    .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic          sign;
    logic [DW-1:0] mag;
    logic [SW-1:0] shift;
    logic          zero;
    int            edges;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;
  bit   seen = 0;
  bit   mon_en = 0;
  logic          l_sign;
  logic [DW-1:0] l_mag;
  logic [SW-1:0] l_shift;
  logic          l_zero;
  logic          p_sign;
  logic [DW-1:0] p_mag;
  logic [SW-1:0] p_shift;
  logic          p_zero;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: |value| as an integer, doubled until its top bit reaches 2^(DW-1).
  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t e;
    int v, a, m, k;
    v = int'($signed(d));
    a = (v < 0) ? -v : v;
    m = a;
    k = 0;
    if (a != 0) while (m < (1 << (DW - 1))) begin m = m * 2; k++; end
    e.din = d; e.sign = (v < 0); e.mag = m[DW-1:0]; e.shift = k[SW-1:0];
    e.zero = (a == 0); e.edges = 3 + k; e.acc_cyc = 0;
    return e;
  endfunction

  task automatic send(input logic [DW-1:0] d);
    exp_t e;
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(d);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (mon_en && rst_n) begin
      if (out_valid) begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else if (!seen) begin
          seen = 1;
          check($sformatf("lat[%0h]", sb[0].din), cyc - sb[0].acc_cyc + 1, sb[0].edges);
          check($sformatf("sign[%0h]", sb[0].din), 32'(out_sign), 32'(sb[0].sign));
          check($sformatf("mag[%0h]", sb[0].din), 32'(out_mag), 32'(sb[0].mag));
          check($sformatf("shift[%0h]", sb[0].din), 32'(out_shift), 32'(sb[0].shift));
          check($sformatf("zero[%0h]", sb[0].din), 32'(out_zero), 32'(sb[0].zero));
        end else begin
          check("stable", {out_sign, out_mag, out_shift, out_zero},
                {p_sign, p_mag, p_shift, p_zero});
        end
        p_sign = out_sign; p_mag = out_mag; p_shift = out_shift; p_zero = out_zero;
        if (out_ready && sb.size() != 0) begin
          l_sign = out_sign; l_mag = out_mag; l_shift = out_shift; l_zero = out_zero;
          void'(sb.pop_front());
          seen = 0;
        end
      end else begin
        check("hold", {out_sign, out_mag, out_shift, out_zero}, {l_sign, l_mag, l_shift, l_zero});
      end
    end
  end

  initial begin
    logic [DW-1:0] dir [6];
    int t;
    dir = '{8'h05, 8'hFB, 8'hFF, 8'h80, 8'h00, 8'h01};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    l_sign = 0; l_mag = '0; l_shift = '0; l_zero = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {out_valid, out_sign, out_mag, out_shift, out_zero}, 0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1;

    foreach (dir[i]) begin send(dir[i]); drain(); end

    // Backpressure: hold out_ready low with a competing word pending on the input.
    @(negedge clk) out_ready = 1'b0;
    send(8'h40);
    in_valid = 1'b1; in_data = 8'h11;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      #2 check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_ready_after", {in_ready, out_valid}, 2'b10);
    send(8'h11);
    drain();

    // Reset during normalization discards the word.
    send(8'h01);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_sign, out_mag, out_shift, out_zero}, 0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete(); seen = 0;
    l_sign = 0; l_mag = '0; l_shift = '0; l_zero = 0;
    @(negedge clk) rst_n = 1'b1;
    send(8'h03);
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(DW'($urandom));
    end
    drain();
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
